// File: rtl/cpu_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: funct codes, FSM states, iteration count.
// The divider is built only when MULDIV_DIV_EN is defined.
package cpu_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: radix-2 shift-add multiply and, with MULDIV_DIV_EN,
// restoring shift-subtract divide. result is the product, or {remainder, quotient}.
module muldiv_core (
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    input  logic        op_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] result
);

    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] opb;
    logic [32:0] mul_sum;

`ifdef MULDIV_DIV_EN
    logic        op_div_q;
    logic [64:0] shifted;
    logic [32:0] diff;
`else
    logic unused_op_div;
    assign unused_op_div = op_div;
`endif

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, high half accumulates.
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        acc_next = {mul_sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
        shifted = {acc, 1'b0};
        diff    = shifted[64:32] - {1'b0, opb};
        if (op_div_q) begin
            acc_next = diff[32] ? shifted[63:0] : {diff[31:0], shifted[31:1], 1'b1};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc <= {32'd0, b_mag};
            opb <= a_mag;
`ifdef MULDIV_DIV_EN
            op_div_q <= op_div;
            if (op_div) begin
                acc <= {32'd0, a_mag};
                opb <= b_mag;
            end
`endif
        end else if (step) begin
            acc <= acc_next;
        end
    end

    assign result = acc;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: launch handshake, FSM, sign fix-up and the HI:LO register.
// Divide support is compiled in only when MULDIV_DIV_EN is defined; otherwise div/divu are illegal.
module muldiv_ctrl
    import cpu_pkg::*;
#(
    parameter logic [63:0] HILO_INIT = 64'h0
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        abort,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] hilo,
    output logic        illegal,
    output logic [1:0]  fsm_state
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              neg_res_q;
    logic              op_legal;
    logic              accept;
    logic [31:0]       a_mag;
    logic [31:0]       b_mag;
    logic [63:0]       core_res;
    logic [63:0]       fixed;

`ifdef MULDIV_DIV_EN
    logic              op_div_q;
    logic              neg_rem_q;
    logic              div0_q;
    logic [31:0]       rs_q;
`endif

    always_comb begin
        op_legal = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
`ifdef MULDIV_DIV_EN
        op_legal = op_legal || (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
`endif
    end

    assign accept = (state == IDLE) && start && op_legal;
    assign a_mag  = (is_signed_op(funct) && rs_val[31]) ? -rs_val : rs_val;
    assign b_mag  = (is_signed_op(funct) && rt_val[31]) ? -rt_val : rt_val;

    muldiv_core u_core (
        .clk    (clka),
        .load   (accept),
        .step   (state == CALC),
        .op_div (funct[1]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .result (core_res)
    );

    // Quotient follows the sign of A xor B, remainder follows A (truncating division).
    always_comb begin
        fixed = neg_res_q ? -core_res : core_res;
`ifdef MULDIV_DIV_EN
        if (op_div_q) begin
            fixed[31:0]  = neg_res_q ? -core_res[31:0]  : core_res[31:0];
            fixed[63:32] = neg_rem_q ? -core_res[63:32] : core_res[63:32];
        end
`endif
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state     <= IDLE;
            hilo      <= HILO_INIT;
            busy      <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            cnt       <= '0;
            neg_res_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            rs_q      <= '0;
`endif
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_we) hilo[63:32] <= wdata;
                    if (lo_we) hilo[31:0]  <= wdata;
                    if (start) begin
                        if (op_legal) begin
                            state     <= CALC;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            neg_res_q <= is_signed_op(funct) && (rs_val[31] ^ rt_val[31]);
`ifdef MULDIV_DIV_EN
                            op_div_q  <= funct[1];
                            neg_rem_q <= is_signed_op(funct) && rs_val[31];
                            div0_q    <= funct[1] && (rt_val == 32'd0);
                            rs_q      <= rs_val;
`endif
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (div0_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                            hilo  <= {rs_q, 32'hFFFF_FFFF};
                        end else
`endif
                        begin
                            cnt <= cnt + 1'b1;
                            if (cnt == LAST_ITER) state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        hilo  <= fixed;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = 2'(state);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl; divide vectors are used when MULDIV_DIV_EN is defined.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
    import cpu_pkg::*;

    localparam logic [63:0] INIT = 64'h1234_5678_9ABC_DEF0;

    logic        clka = 1'b0;
    logic        rst, start, abort, hi_we, lo_we;
    logic [5:0]  funct;
    logic [31:0] rs_val, rt_val, wdata;
    logic        busy, done, illegal;
    logic [63:0] hilo;
    logic [1:0]  fsm_state;

    logic [63:0] exp_q[$];
    logic [63:0] model_hilo;
    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_ctrl #(.HILO_INIT(INIT)) dut (
        .clka(clka), .rst(rst), .start(start), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .abort(abort),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hilo(hilo), .illegal(illegal),
        .fsm_state(fsm_state)
    );

    always #5 clka = ~clka;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d expected results outstanding", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clka) begin
        logic [63:0] e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done_pulse: done seen with no request outstanding, hilo=%h", hilo);
            end else begin
                e = exp_q.pop_front();
                check("hilo_result", hilo, e);
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge (edge k); returns at the negedge after k.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct  = f;
        rs_val = a;
        rt_val = b;
        @(negedge clka);
        start  = 1'b0;
    endtask

    task automatic wait_op(input string name, input int cyc0, input int exp_lat, input logic [63:0] exp);
        int   cyc;
        logic busy_ok;
        cyc     = cyc0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clka);
            cyc++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
        @(negedge clka);
        check({name, "_busy_during"}, 64'(busy_ok), 64'd1);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        model_hilo = exp;
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        exp_q.push_back(exp);
        issue(f, a, b);
        wait_op(name, 0, exp_lat, exp);
    endtask

    task automatic expect_illegal(input string name, input logic [5:0] f);
        issue(f, 32'd9, 32'd3);
        check({name, "_pulse"}, 64'(illegal), 64'd1);
        check({name, "_busy"}, 64'(busy), 64'd0);
        @(negedge clka);
        check({name, "_pulse_end"}, 64'(illegal), 64'd0);
        check({name, "_hilo"}, hilo, model_hilo);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        funct = '0; rs_val = '0; rt_val = '0; wdata = '0;
        repeat (3) @(negedge clka);
        check("reset_hilo", hilo, INIT);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_illegal", 64'(illegal), 64'd0);
        check("reset_state", 64'(fsm_state), 64'(IDLE));
        rst = 1'b0;
        model_hilo = INIT;
        @(negedge clka);

        run_op("mult_7_m3",    FUNCT_MULT,  32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 33);
        run_op("multu_max_2",  FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, 33);
        run_op("mult_m5_m6",   FUNCT_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'h0000_0000_0000_001E, 33);
        run_op("mult_min_min", FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
        run_op("multu_max_sq", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);

        // mthi / mtlo in IDLE
        hi_we = 1'b1; wdata = 32'hAAAA_5555;
        @(negedge clka);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555_AAAA;
        model_hilo[63:32] = 32'hAAAA_5555;
        check("mthi", hilo, model_hilo);
        @(negedge clka);
        lo_we = 1'b0;
        model_hilo[31:0] = 32'h5555_AAAA;
        check("mtlo", hilo, model_hilo);

        // abort in IDLE does nothing
        abort = 1'b1;
        @(negedge clka);
        abort = 1'b0;
        check("abort_idle_state", 64'(fsm_state), 64'(IDLE));
        check("abort_idle_hilo", hilo, model_hilo);

        // writes and a second start while busy are ignored
        exp_q.push_back(64'h0000_0000_0000_0100);
        issue(FUNCT_MULTU, 32'h10, 32'h10);
        repeat (4) @(negedge clka);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_BABE;
        start = 1'b1; funct = FUNCT_MULT; rs_val = 32'd5; rt_val = 32'd5;
        @(negedge clka);
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        check("write_while_busy", hilo, model_hilo);
        wait_op("busy_ignore", 5, 33, 64'h0000_0000_0000_0100);

        // start and mthi in the same IDLE cycle: write lands, DONE overwrites later
        exp_q.push_back(64'h0000_0000_0000_0006);
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        issue(FUNCT_MULT, 32'd2, 32'd3);
        hi_we = 1'b0;
        check("start_with_write", hilo, {32'hDEAD_BEEF, model_hilo[31:0]});
        wait_op("start_with_write", 0, 33, 64'h0000_0000_0000_0006);

        // abort sampled at k+11 of a mult
        issue(FUNCT_MULT, 32'd3, 32'd4);
        repeat (10) @(negedge clka);
        abort = 1'b1;
        @(negedge clka);
        abort = 1'b0;
        check("abort_state", 64'(fsm_state), 64'(IDLE));
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", hilo, model_hilo);
        run_op("after_abort", FUNCT_MULT, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 33);

        // reset at k+20
        issue(FUNCT_MULTU, 32'd1234, 32'd5678);
        repeat (19) @(negedge clka);
        rst = 1'b1;
        @(negedge clka);
        rst = 1'b0;
        model_hilo = INIT;
        check("midop_reset_hilo", hilo, INIT);
        check("midop_reset_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clka);
        check("midop_reset_no_result", hilo, model_hilo);

        expect_illegal("illegal_funct", 6'b100000);

`ifdef MULDIV_DIV_EN
        run_op("div_m7_2",    FUNCT_DIV,  32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("divu_100_0",  FUNCT_DIVU, 32'h64,        32'd0,         64'h0000_0064_FFFF_FFFF, 1);
        run_op("div_ovf",     FUNCT_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);
        run_op("divu_100_7",  FUNCT_DIVU, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 33);
        run_op("div_7_m2",    FUNCT_DIV,  32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33);
`else
        expect_illegal("div_disabled", FUNCT_DIV);
        expect_illegal("divu_disabled", FUNCT_DIVU);
`endif

        repeat (3) @(negedge clka);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
